key_input_ctrl: RTL and testbench

Front-end input stage that sits directly upstream of the game state machine. It converts raw USB-HID keycodes into three things: a sticky command byte (space/P/R), a latched Pac-Man direction that is committed on each game tick, and the game_clock tick itself. The state machine consumes keyboard and game_clock and drives read_req. The movement/paint logic consumes dir and dir_commit.

---
 rtl/game_pkg.sv | 40 ++++
 rtl/key_input_ctrl_if.sv | 24 ++
 rtl/key_input_ctrl_tick_gen.sv | 31 +++
 rtl/key_input_ctrl.sv | 85 ++++++++
 tb/tb_key_input_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - HID keycode constants and direction type shared by the game front end
package game_pkg;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_P     = 8'h13;
  localparam logic [7:0] KEY_R     = 8'h15;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  function automatic logic is_cmd_key(input logic [7:0] kc);
    return (kc == KEY_SPACE) || (kc == KEY_P) || (kc == KEY_R);
  endfunction

  // Non-direction keys map to DIR_NONE, which doubles as "not a direction key".
  function automatic dir_t key_to_dir(input logic [7:0] kc);
    case (kc)
      KEY_W, KEY_UP:     return DIR_UP;
      KEY_S, KEY_DOWN:   return DIR_DOWN;
      KEY_A, KEY_LEFT:   return DIR_LEFT;
      KEY_D, KEY_RIGHT:  return DIR_RIGHT;
      default:           return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/key_input_ctrl_if.sv
// rtl/key_input_ctrl_if.sv - keyboard/state-machine/movement signals of the key input stage
interface key_input_ctrl_if;
  import game_pkg::*;

  logic [7:0] keycode;
  logic       read_req;
  logic       tick_en;
  logic [7:0] keyboard;
  logic       game_clock;
  dir_t       dir;
  logic       dir_commit;
  logic       pend_valid;

  modport master (
    output keycode, read_req, tick_en,
    input  keyboard, game_clock, dir, dir_commit, pend_valid
  );

  modport slave (
    input  keycode, read_req, tick_en,
    output keyboard, game_clock, dir, dir_commit, pend_valid
  );

endinterface

// File: rtl/key_input_ctrl_tick_gen.sv
// rtl/key_input_ctrl_tick_gen.sv - registered one-cycle game tick every TICK_DIV cycles
module tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);

  logic [CW-1:0] cnt;

  // tick is registered one count early so it is high exactly while cnt == LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      tick <= (cnt == PRE);
    end
  end

endmodule

// File: rtl/key_input_ctrl.sv
// rtl/key_input_ctrl.sv - keycode to command byte, committed direction and game tick
module key_input_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 2
) (
  input logic             clk,
  input logic             reset,
  key_input_ctrl_if.slave kif
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;

  logic [7:0] kc_q;
  logic [7:0] kc_q2;
  logic [7:0] keyboard_q;
  logic       new_press;
  logic       dir_press;
  logic       paused;
  logic       tick_clr;
  logic       game_clock;
  logic       commit;
  logic       pend_valid;
  logic       dir_commit;
  dir_t       press_dir;
  dir_t       pend_dir;
  dir_t       dir_q;

  assign new_press = (kc_q != kc_q2) && (kc_q != KEY_NONE);
  assign press_dir = key_to_dir(kc_q);
  assign dir_press = new_press && (press_dir != DIR_NONE);
  assign paused    = (keyboard_q == KEY_P);
  assign tick_clr  = !kif.tick_en || paused;
  assign commit    = game_clock && kif.read_req && pend_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kc_q       <= KEY_NONE;
      kc_q2      <= KEY_NONE;
      keyboard_q <= KEY_NONE;
    end else begin
      kc_q  <= kif.keycode;
      kc_q2 <= kc_q;
      if (new_press && is_cmd_key(kc_q))
        keyboard_q <= kc_q;
    end
  end

  // A press coinciding with a commit becomes the next pending value; the commit takes the old one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_dir   <= DIR_NONE;
      pend_valid <= 1'b0;
      dir_q      <= DIR_NONE;
      dir_commit <= 1'b0;
    end else begin
      dir_commit <= commit;
      if (commit)
        dir_q <= pend_dir;
      if (dir_press) begin
        pend_dir   <= press_dir;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
    end
  end

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (tick_clr),
    .tick (game_clock)
  );

  assign kif.keyboard   = keyboard_q;
  assign kif.game_clock = game_clock;
  assign kif.dir        = dir_q;
  assign kif.dir_commit = dir_commit;
  assign kif.pend_valid = pend_valid;

endmodule

// File: tb/tb_key_input_ctrl.sv
// tb/tb_key_input_ctrl.sv - scoreboard bench for key_input_ctrl at TICK_DIV = 10
module tb_key_input_ctrl;
  import game_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  dir_t exp_q[$];
  logic gc_prev = 1'b0;

  key_input_ctrl_if kif();

  key_input_ctrl #(
    .CLK_HZ (20),
    .TICK_HZ(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kif  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Steps until a negedge sample shows game_clock high, then checks how many steps that took.
  task automatic tick_after(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!kif.game_clock && n < 40);
    check(name, n, exp_n);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (kif.dir_commit) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got dir %0d expected no commit", kif.dir);
        end else begin
          check("commit_dir", kif.dir, exp_q.pop_front());
        end
      end
      if (gc_prev)
        check("tick_width", kif.game_clock, 0);
    end
    gc_prev <= kif.game_clock;
  end

  initial begin
    int gc_count;
    reset        = 1'b1;
    kif.keycode  = KEY_NONE;
    kif.read_req = 1'b0;
    kif.tick_en  = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_keyboard", kif.keyboard, 0);
    check("rst_game_clock", kif.game_clock, 0);
    check("rst_dir", kif.dir, 0);
    check("rst_dir_commit", kif.dir_commit, 0);
    check("rst_pend_valid", kif.pend_valid, 0);
    reset = 1'b1;

    // 1: tick cadence
    tick_after("first_tick", 9);
    tick_after("tick_period", 10);

    // 2: held up-arrow commits once
    kif.keycode  = KEY_UP;
    kif.read_req = 1'b1;
    step(1);
    check("s2_pend_lag1", kif.pend_valid, 0);
    step(1);
    check("s2_pend_lag2", kif.pend_valid, 1);
    exp_q.push_back(DIR_UP);
    tick_after("s2_tick", 8);
    step(1);
    check("s2_dir", kif.dir, 1);
    check("s2_pend_clear", kif.pend_valid, 0);
    tick_after("s2_hold_tick1", 9);
    tick_after("s2_hold_tick2", 10);

    // 3: last press wins, then read_req low holds the pending value
    kif.keycode = KEY_A;
    step(2);
    kif.keycode = KEY_D;
    step(2);
    kif.keycode = KEY_NONE;
    exp_q.push_back(DIR_RIGHT);
    tick_after("s3_tick", 6);
    step(1);
    check("s3_dir_last", kif.dir, 4);
    check("s3_pend_clear", kif.pend_valid, 0);
    kif.read_req = 1'b0;
    kif.keycode  = KEY_S;
    step(2);
    check("s3_pend_set", kif.pend_valid, 1);
    kif.keycode = KEY_NONE;
    tick_after("s3_noreq_tick", 7);
    step(1);
    check("s3_dir_held", kif.dir, 4);
    check("s3_pend_kept", kif.pend_valid, 1);
    kif.read_req = 1'b1;
    exp_q.push_back(DIR_DOWN);
    tick_after("s3_req_tick", 9);
    step(1);
    check("s3_dir_down", kif.dir, 2);

    // 4: pause stops ticks but still latches directions; resume restarts the count
    tick_after("s4_align", 9);
    kif.keycode = KEY_P;
    step(2);
    check("s4_keyboard_p", kif.keyboard, 8'h13);
    gc_count = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10)
        kif.keycode = KEY_W;
      @(negedge clk);
      if (kif.game_clock)
        gc_count++;
    end
    check("s4_no_ticks", gc_count, 0);
    check("s4_pend_paused", kif.pend_valid, 1);
    check("s4_keyboard_held", kif.keyboard, 8'h13);
    kif.keycode = KEY_R;
    exp_q.push_back(DIR_UP);
    step(2);
    check("s4_keyboard_r", kif.keyboard, 8'h15);
    tick_after("s4_resume_tick", 9);
    step(1);
    check("s4_dir", kif.dir, 1);

    // 5: new press in the same cycle as a commit tick
    tick_after("s5_align", 9);
    kif.keycode = KEY_A;
    step(2);
    check("s5_pend_left", kif.pend_valid, 1);
    kif.keycode = KEY_NONE;
    step(7);
    kif.keycode = KEY_D;
    exp_q.push_back(DIR_LEFT);
    exp_q.push_back(DIR_RIGHT);
    step(1);
    check("s5_tick_here", kif.game_clock, 1);
    step(1);
    check("s5_dir_old", kif.dir, 3);
    check("s5_pend_new", kif.pend_valid, 1);
    kif.keycode = KEY_NONE;
    tick_after("s5_next_tick", 9);
    step(1);
    check("s5_dir_new", kif.dir, 4);
    check("s5_pend_clear", kif.pend_valid, 0);

    // 6: asynchronous reset mid-count discards pending
    tick_after("s6_align", 9);
    kif.keycode = KEY_A;
    exp_q.push_back(DIR_LEFT);
    step(2);
    kif.keycode = KEY_NONE;
    tick_after("s6_tick", 8);
    step(1);
    check("s6_dir_left", kif.dir, 3);
    kif.keycode = KEY_DOWN;
    step(2);
    check("s6_pend_set", kif.pend_valid, 1);
    kif.keycode = KEY_NONE;
    step(2);
    #2 reset = 1'b0;
    #1;
    check("s6_async_dir", kif.dir, 0);
    check("s6_async_pend", kif.pend_valid, 0);
    check("s6_async_keyboard", kif.keyboard, 0);
    check("s6_async_gc", kif.game_clock, 0);
    check("s6_async_commit", kif.dir_commit, 0);
    @(negedge clk);
    reset = 1'b1;
    tick_after("s6_first_tick", 9);
    step(1);
    check("s6_dir_after", kif.dir, 0);
    tick_after("s6_second_tick", 9);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
